elevator_call_panel: RTL and testbench

Request front end for the two-floor elevator controller. Synchronises and debounces the four raw call keys (hall up, hall down, cabin to-one, cabin to-two), latches each as a pending call, and issues one request at a time as a single-cycle pulse on `up`/`down`/`toOne`/`toTwo`. A pulse goes out only when the controller is idle. The next call is held until the controller has started and finished the trip. Sits between the board keys and the logic unit; `call_led` drives the request indicator LEDs.

---
 rtl/elevator_call_panel.sv | 196 +++++++++++++++++++
 tb/tb_elevator_call_panel.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_call_panel.sv
// ---------------------------------------------------------------------------
// elevator_call_panel
//
// Request front end for the two-floor elevator controller. Each raw call key
// is synchronised, debounced and latched as a pending call. Calls are then
// issued one at a time as single-cycle pulses, and only while the controller
// is idle. The next call waits until the controller has started and finished
// the trip, or until the acknowledge timeout has expired.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a key level (>= 2)
//   ACK_TIMEOUT      cycles to wait for the controller to leave idle
//
// Ports:
//   clk_50mhz   in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   key_up      in   raw hall-up key (asynchronous, bouncy)
//   key_down    in   raw hall-down key
//   key_to_one  in   raw cabin "floor 1" key
//   key_to_two  in   raw cabin "floor 2" key
//   start_stop  in   run enable; 0 freezes issuing, latching continues
//   state[3:0]  in   controller state, 0 = idle
//   floor[1:0]  in   current floor, 1 or 2
//   up, down, toOne, toTwo  out  single-cycle request pulses (one-hot)
//   call_led[3:0]           out  pending calls {toTwo, toOne, down, up}
//
// Optional feature macro: CALL_PANEL_CANCEL_EN
//   defined     a new press of an already pending call cancels it
//   undefined   a repeated press while pending is ignored
// ---------------------------------------------------------------------------
module elevator_call_panel #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int ACK_TIMEOUT     = 16
) (
   input  logic       clk_50mhz,
   input  logic       rst,
   input  logic       key_up,
   input  logic       key_down,
   input  logic       key_to_one,
   input  logic       key_to_two,
   input  logic       start_stop,
   input  logic [3:0] state,
   input  logic [1:0] floor,
   output logic       up,
   output logic       down,
   output logic       toOne,
   output logic       toTwo,
   output logic [3:0] call_led
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int TO_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } fsm_t;

   // Bit order everywhere: 0 = up, 1 = down, 2 = toOne, 3 = toTwo
   logic [3:0]      w_keys;
   logic [3:0]      r_sync1;
   logic [3:0]      r_sync2;
   logic [3:0]      r_deb;
   logic [3:0]      r_deb_q;
   logic [3:0]      r_mask;
   logic [1:0]      r_settle;
   logic [DB_W-1:0] r_db_cnt [4];

   logic [3:0]      r_pend;
   logic [3:0]      r_pulse;
   logic [TO_W-1:0] r_to_cnt;
   fsm_t            r_fsm;

   logic [3:0]      w_rise;
   logic [3:0]      w_valid;
   logic [3:0]      w_elig;
   logic [3:0]      w_sel;
   logic [3:0]      w_clr;
   logic [3:0]      w_pend_nxt;
   logic            w_launch;

   assign w_keys = {key_to_two, key_to_one, key_down, key_up};

   // Synchroniser and per-key debounce. A key held through reset stays
   // masked until it has been seen released, so it cannot fake a press.
   // r_settle waits out the two synchroniser stages after reset before the
   // synchronised level is trusted for unmasking.
   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_deb    <= '0;
         r_deb_q  <= '0;
         r_mask   <= '1;
         r_settle <= '0;
         for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
      end else begin
         r_sync1  <= w_keys;
         r_sync2  <= r_sync1;
         r_deb_q  <= r_deb;
         r_settle <= {r_settle[0], 1'b1};
         for (int i = 0; i < 4; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DB_LAST) begin
               r_deb[i]    <= r_sync2[i];
               r_db_cnt[i] <= '0;
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
            end
            if (r_settle[1] && !r_sync2[i]) r_mask[i] <= 1'b0;
         end
      end
   end

   assign w_rise = r_deb & ~r_deb_q & ~r_mask;

   // up and toTwo only make sense on floor 1, down and toOne on floor 2
   assign w_valid = {floor == 2'd1, floor == 2'd2, floor == 2'd2, floor == 2'd1};
   assign w_elig  = r_pend & w_valid;

   // Fixed priority: toOne > toTwo > up > down
   always_comb begin
      w_sel = 4'b0000;
      if (w_elig[2])      w_sel = 4'b0100;
      else if (w_elig[3]) w_sel = 4'b1000;
      else if (w_elig[0]) w_sel = 4'b0001;
      else if (w_elig[1]) w_sel = 4'b0010;
   end

   assign w_launch = (r_fsm == S_IDLE) && (|w_elig) && start_stop && (state == 4'd0);
   assign w_clr    = w_launch ? w_sel : 4'b0000;

   always_comb begin
      w_pend_nxt = 4'b0000;
`ifdef CALL_PANEL_CANCEL_EN
      // A press on a pending call cancels it, unless that call is being
      // issued this cycle, in which case the issue wins.
      w_pend_nxt = (r_pend & ~w_clr & ~w_rise) | (~r_pend & w_rise);
`else
      // A press coinciding with its own issue re-arms the call as new.
      w_pend_nxt = (r_pend & ~w_clr) | w_rise;
`endif
      w_pend_nxt = w_pend_nxt & w_valid;
   end

   always_ff @(posedge clk_50mhz) begin
      if (rst) r_pend <= '0;
      else     r_pend <= w_pend_nxt;
   end

   // Issue handshake: pulse, wait for the controller to go busy (or time
   // out and drop the call), then wait for it to return to idle.
   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         r_fsm    <= S_IDLE;
         r_pulse  <= '0;
         r_to_cnt <= '0;
      end else begin
         case (r_fsm)
            S_IDLE: begin
               r_pulse <= '0;
               if (w_launch) begin
                  r_pulse <= w_sel;
                  r_fsm   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_pulse  <= '0;
               r_to_cnt <= '0;
               r_fsm    <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (state != 4'd0)          r_fsm <= S_WAIT_DONE;
               else if (r_to_cnt == TO_LAST) r_fsm <= S_IDLE;
               else                        r_to_cnt <= r_to_cnt + TO_W'(1);
            end
            S_WAIT_DONE: begin
               if (state == 4'd0) r_fsm <= S_IDLE;
            end
            default: r_fsm <= S_IDLE;
         endcase
      end
   end

   assign up       = r_pulse[0];
   assign down     = r_pulse[1];
   assign toOne    = r_pulse[2];
   assign toTwo    = r_pulse[3];
   assign call_led = r_pend;

endmodule

// File: tb/tb_elevator_call_panel.sv
// ---------------------------------------------------------------------------
// tb_elevator_call_panel
//
// Directed bench for elevator_call_panel with DEBOUNCE_CYCLES=4 and
// ACK_TIMEOUT=8. A behavioural model (sliding-window debounce, timestamped
// trip tracking) predicts the pulses and LEDs on every cycle; directed
// scenarios add hand-computed literal expectations on top.
// ---------------------------------------------------------------------------
module tb_elevator_call_panel;

   localparam int D   = 4;
   localparam int ACK = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       k_up, k_down, k_one, k_two;
   logic       start_stop;
   logic [3:0] state;
   logic [1:0] floor;
   logic       up, down, toOne, toTwo;
   logic [3:0] call_led;
   logic [3:0] o_pulses;

   always #5 clk = ~clk;

   elevator_call_panel #(
      .DEBOUNCE_CYCLES(D),
      .ACK_TIMEOUT    (ACK)
   ) dut (
      .clk_50mhz (clk),
      .rst       (rst),
      .key_up    (k_up),
      .key_down  (k_down),
      .key_to_one(k_one),
      .key_to_two(k_two),
      .start_stop(start_stop),
      .state     (state),
      .floor     (floor),
      .up        (up),
      .down      (down),
      .toOne     (toOne),
      .toTwo     (toTwo),
      .call_led  (call_led)
   );

   assign o_pulses = {toTwo, toOne, down, up};

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // ---------------- behavioural model ----------------
   // bit order: 0 up, 1 down, 2 toOne, 3 toTwo
   logic [3:0] m_pend, m_pulse, m_deb, m_armed, m_rose;
   bit         m_lock, m_acked;
   int         m_t0;
   logic [4:0] hist [$];   // {sample taken outside reset, raw keys}

   function automatic logic [3:0] pick(input logic [3:0] e);
      if (e[2]) return 4'b0100;
      if (e[3]) return 4'b1000;
      if (e[0]) return 4'b0001;
      if (e[1]) return 4'b0010;
      return 4'b0000;
   endfunction

   task automatic model_edge();
      logic [3:0] v, elig, sel, clr, rise, nxt;
      logic       issue, nb, lvl, same;
      int         idx;
      if (rst) begin
         hist.push_back(5'b0);
         m_pend = '0; m_pulse = '0; m_deb = '0; m_armed = '0; m_rose = '0;
         m_lock = 0; m_acked = 0; m_t0 = 0;
         return;
      end
      hist.push_back({1'b1, k_two, k_one, k_down, k_up});
      v     = {floor == 2'd1, floor == 2'd2, floor == 2'd2, floor == 2'd1};
      elig  = m_pend & v;
      sel   = pick(elig);
      issue = !m_lock && (elig != 0) && start_stop && (state == 4'd0);
      clr   = issue ? sel : 4'b0000;
      rise  = m_rose & m_armed;
      for (int k = 0; k < 4; k++) begin
`ifdef CALL_PANEL_CANCEL_EN
         if (m_pend[k]) nb = !clr[k] && !rise[k];
         else           nb = rise[k];
`else
         nb = (m_pend[k] && !clr[k]) || rise[k];
`endif
         nxt[k] = nb && v[k];
      end
      m_pend  = nxt;
      m_pulse = '0;
      if (!m_lock) begin
         if (issue) begin
            m_lock = 1; m_t0 = cyc; m_acked = 0; m_pulse = sel;
         end
      end else if (cyc >= m_t0 + 2) begin
         if (m_acked) begin
            if (state == 4'd0) m_lock = 0;
         end else if (state != 4'd0) begin
            m_acked = 1;
         end else if (cyc == m_t0 + ACK + 1) begin
            m_lock = 0;
         end
      end
      // debounced level follows D consecutive synchronised samples
      idx    = hist.size() - 1;
      m_rose = '0;
      for (int k = 0; k < 4; k++) begin
         if (idx >= 2 && hist[idx-2][4] && !hist[idx-2][k]) m_armed[k] = 1'b1;
         if (idx - 1 - D >= 0) begin
            lvl  = hist[idx-2][k];
            same = 1'b1;
            for (int j = 0; j < D; j++) if (hist[idx-2-j][k] != lvl) same = 1'b0;
            if (same && lvl != m_deb[k]) begin
               m_deb[k] = lvl;
               if (lvl) m_rose[k] = 1'b1;
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
      model_edge();
   end

   // ---------------- compare + monitor ----------------
   int pc [4];
   int first [4];
   int led_hi [4];

   task automatic clr_mon();
      for (int k = 0; k < 4; k++) begin
         pc[k] = 0; first[k] = -1; led_hi[k] = 0;
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (cyc >= 1) begin
         n_cmp++;
         if (o_pulses !== m_pulse || call_led !== m_pend) begin
            n_bad++;
            $display("FAIL model_cmp cyc=%0d pulses got %b exp %b led got %b exp %b",
                     cyc, o_pulses, m_pulse, call_led, m_pend);
         end
         for (int k = 0; k < 4; k++) begin
            if (o_pulses[k] === 1'b1) begin
               pc[k]++;
               if (first[k] < 0) first[k] = cyc;
            end
            if (call_led[k] === 1'b1) led_hi[k]++;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #2;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   int t_s, tp;

   initial begin
      clr_mon();
      rst = 1; k_up = 0; k_down = 0; k_one = 0; k_two = 0;
      start_stop = 1; state = 4'd0; floor = 2'd1;
      tick(3);
      chk("reset_led", int'(call_led), 0);
      chk("reset_pulses", int'(o_pulses), 0);
      rst = 0;
      tick(5);

      // bounced toTwo press on floor 1
      clr_mon();
      k_two = 1; tick();
      k_two = 0; tick();
      k_two = 1; t_s = cyc;
      tick(20);
      chk("t1_toTwo_count", pc[3], 1);
      chk("t1_latency", first[3] - t_s, 8);
      chk("t1_led_cycles", led_hi[3], 1);
      k_two = 0;
      tick(20);

      // down on floor 1 is invalid
      clr_mon();
      k_down = 1;
      tick(15);
      chk("t2_down_count", pc[1], 0);
      chk("t2_led", int'(call_led), 0);
      chk("t2_led_seen", led_hi[1], 0);
      k_down = 0;
      tick(10);

      // ack timeout with state held idle, next call waits it out
      clr_mon();
      k_two = 1;
      for (int i = 0; i < 30 && pc[3] == 0; i++) tick();
      chk("t4_toTwo_seen", pc[3], 1);
      tp = first[3];
      k_up = 1;
      tick(20);
      chk("t4_up_count", pc[0], 1);
      chk("t4_up_after_timeout", first[0] - tp, ACK + 2);
      chk("t4_no_repulse", pc[3], 1);
      k_up = 0; k_two = 0;
      tick(20);

      // floor 2: priority, busy hold, invalid up dropped
      floor = 2'd2; state = 4'd1;
      clr_mon();
      k_up = 1; k_down = 1;
      tick(2);
      k_one = 1;
      tick(15);
      chk("t3_led_pending", int'(call_led), 6);
      chk("t3_no_pulse_busy", pc[2] + pc[1] + pc[0], 0);
      state = 4'd0;
      for (int i = 0; i < 10 && pc[2] == 0; i++) tick();
      chk("t3_toOne_count", pc[2], 1);
      state = 4'd1;
      tick(10);
      chk("t3_down_held", int'(call_led), 2);
      tick(10);
      state = 4'd0; t_s = cyc;
      tick(10);
      chk("t3_down_count", pc[1], 1);
      chk("t3_down_delay", first[1] - t_s, 2);
      chk("t3_toOne_first", int'(first[2] < first[1]), 1);
      chk("t3_up_dropped", pc[0], 0);
      k_up = 0; k_down = 0; k_one = 0;
      tick(20);

      // start_stop gating
      floor = 2'd1; start_stop = 0;
      clr_mon();
      k_up = 1;
      tick(12);
      chk("t5_led_held", int'(call_led), 1);
      chk("t5_no_pulse", pc[0], 0);
      k_up = 0;
      tick(5);
      chk("t5_led_still", int'(call_led), 1);
      start_stop = 1; t_s = cyc;
      tick(3);
      chk("t5_pulse_count", pc[0], 1);
      chk("t5_pulse_delay", first[0] - t_s, 1);
      tick(20);

      // repeated press while pending
      start_stop = 0;
      clr_mon();
      k_up = 1; tick(10);
      chk("t6_first_press", int'(call_led), 1);
      k_up = 0; tick(10);
      k_up = 1; tick(10);
`ifdef CALL_PANEL_CANCEL_EN
      chk("t6_cancelled", int'(call_led), 0);
`else
      chk("t6_still_pending", int'(call_led), 1);
`endif
      chk("t6_no_pulse", pc[0], 0);
      k_up = 0; tick(10);
      start_stop = 1;
      tick(20);

      // reset mid-trip with keys held through reset
      clr_mon();
      k_two = 1;
      for (int i = 0; i < 30 && pc[3] == 0; i++) tick();
      chk("t7_toTwo_seen", pc[3], 1);
      state = 4'd1; k_up = 1;
      tick(10);
      chk("t7_up_pending", int'(call_led), 1);
      rst = 1;
      tick(2);
      chk("t7_reset_led", int'(call_led), 0);
      chk("t7_reset_pulses", int'(o_pulses), 0);
      rst = 0; state = 4'd0;
      clr_mon();
      tick(20);
      chk("t7_held_no_pulse", pc[0] + pc[3], 0);
      chk("t7_held_no_led", int'(call_led), 0);
      k_up = 0; k_two = 0;
      tick(10);
      k_up = 1;
      tick(12);
      chk("t7_fresh_press", pc[0], 1);
      k_up = 0;
      tick(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
